// File: rtl/dma_ch_sched.sv
// Round-robin scheduler sharing one read-command and one write-command DMA engine among N_CH channels.
// Optional watchdog with err output: define DMA_SCHED_TIMEOUT_EN.
module dma_ch_sched #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int N_CH             = 4,
   parameter int TIMEOUT_CYCLES   = 65535
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_CH-1:0]                ch_req,
   input  logic [N_CH*C_AXI_DATA_WIDTH-1:0] ch_src_addr,
   input  logic [N_CH*C_AXI_DATA_WIDTH-1:0] ch_dst_addr,
   input  logic [N_CH*16-1:0]             ch_size,
   output logic [N_CH-1:0]                ch_ack,
   output logic [N_CH-1:0]                ch_done,
   output logic                           rd_start,
   output logic [C_AXI_DATA_WIDTH-1:0]    rd_src_addr,
   output logic [15:0]                    rd_size,
   input  logic                           rd_done,
   output logic                           wr_start,
   output logic [C_AXI_DATA_WIDTH-1:0]    wr_dst_addr,
   output logic [15:0]                    wr_size,
   input  logic                           wr_done,
   output logic                           busy,
   output logic [2:0]                     cur_ch
`ifdef DMA_SCHED_TIMEOUT_EN
   ,
   output logic                           err
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   if (N_CH < 2 || N_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("dma_ch_sched: N_CH must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   logic [1:0]                  state;
   logic [2:0]                  last_grant;
   logic                        rd_seen;
   logic                        wr_seen;
   logic                        any_req;
   logic                        any_hi;
   logic [2:0]                  win_hi;
   logic [2:0]                  win_lo;
   logic [2:0]                  winner;
   logic [N_CH-1:0]             win_oh;
   logic [N_CH-1:0]             cur_oh;
   logic [C_AXI_DATA_WIDTH-1:0] sel_src;
   logic [C_AXI_DATA_WIDTH-1:0] sel_dst;
   logic [15:0]                 sel_size;
   logic                        both_done;
`ifdef DMA_SCHED_TIMEOUT_EN
   logic [31:0]                 wdog;
`endif

   // Two-pass priority: lowest requester above last_grant, else lowest at or below it.
   always_comb begin
      any_hi = 1'b0;
      win_hi = '0;
      win_lo = '0;
      for (int unsigned c = N_CH; c > 0; c--) begin
         if (ch_req[c-1] && (c-1) > 32'(last_grant)) begin
            any_hi = 1'b1;
            win_hi = 3'(c-1);
         end
         if (ch_req[c-1] && (c-1) <= 32'(last_grant)) begin
            win_lo = 3'(c-1);
         end
      end
      winner  = any_hi ? win_hi : win_lo;
      any_req = |ch_req;
   end

   always_comb begin
      win_oh   = '0;
      cur_oh   = '0;
      sel_src  = '0;
      sel_dst  = '0;
      sel_size = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         if (winner == 3'(c)) begin
            win_oh[c] = 1'b1;
            sel_src   = ch_src_addr[c*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH];
            sel_dst   = ch_dst_addr[c*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH];
            sel_size  = ch_size[c*16 +: 16];
         end
         if (cur_ch == 3'(c)) begin
            cur_oh[c] = 1'b1;
         end
      end
      both_done = (rd_seen | rd_done) & (wr_seen | wr_done);
   end

   // ch_done is registered on the WAIT->DONE edge so it appears one cycle after the final done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         last_grant  <= 3'(N_CH-1);
         rd_seen     <= 1'b0;
         wr_seen     <= 1'b0;
         ch_ack      <= '0;
         ch_done     <= '0;
         rd_start    <= 1'b0;
         wr_start    <= 1'b0;
         rd_src_addr <= '0;
         wr_dst_addr <= '0;
         rd_size     <= '0;
         wr_size     <= '0;
         busy        <= 1'b0;
         cur_ch      <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
         wdog        <= '0;
         err         <= 1'b0;
`endif
      end else begin
         ch_ack   <= '0;
         ch_done  <= '0;
         rd_start <= 1'b0;
         wr_start <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
         err      <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  rd_src_addr <= sel_src;
                  wr_dst_addr <= sel_dst;
                  rd_size     <= sel_size;
                  wr_size     <= sel_size;
                  cur_ch      <= winner;
                  ch_ack      <= win_oh;
                  busy        <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               rd_start <= 1'b1;
               wr_start <= 1'b1;
`ifdef DMA_SCHED_TIMEOUT_EN
               wdog     <= '0;
`endif
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (rd_done) rd_seen <= 1'b1;
               if (wr_done) wr_seen <= 1'b1;
               if (both_done) begin
                  ch_done <= cur_oh;
                  state   <= S_DONE;
               end
`ifdef DMA_SCHED_TIMEOUT_EN
               else if (wdog == 32'(TIMEOUT_CYCLES-1)) begin
                  ch_done <= cur_oh;
                  err     <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  wdog <= wdog + 32'd1;
               end
`endif
            end
            S_DONE: begin
               last_grant <= cur_ch;
               rd_seen    <= 1'b0;
               wr_seen    <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_ch_sched.sv
// Scoreboard bench for dma_ch_sched: driver pushes expected grants/starts/completions, monitor pops and compares.
module tb_dma_ch_sched;
   localparam int N = 4;
   localparam int W = 32;
`ifdef DMA_SCHED_TIMEOUT_EN
   localparam int TO = 100;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   ch_req;
   logic [N*W-1:0] ch_src_addr;
   logic [N*W-1:0] ch_dst_addr;
   logic [N*16-1:0] ch_size;
   logic [N-1:0]   ch_ack;
   logic [N-1:0]   ch_done;
   logic           rd_start;
   logic [W-1:0]   rd_src_addr;
   logic [15:0]    rd_size;
   logic           rd_done;
   logic           wr_start;
   logic [W-1:0]   wr_dst_addr;
   logic [15:0]    wr_size;
   logic           wr_done;
   logic           busy;
   logic [2:0]     cur_ch;
`ifdef DMA_SCHED_TIMEOUT_EN
   logic           err;
`endif

   always #5 clk = ~clk;

   dma_ch_sched #(
      .C_AXI_DATA_WIDTH(W),
      .N_CH(N)
`ifdef DMA_SCHED_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TO)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_req(ch_req),
      .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr), .ch_size(ch_size),
      .ch_ack(ch_ack), .ch_done(ch_done),
      .rd_start(rd_start), .rd_src_addr(rd_src_addr), .rd_size(rd_size), .rd_done(rd_done),
      .wr_start(wr_start), .wr_dst_addr(wr_dst_addr), .wr_size(wr_size), .wr_done(wr_done),
      .busy(busy), .cur_ch(cur_ch)
`ifdef DMA_SCHED_TIMEOUT_EN
      , .err(err)
`endif
   );

   typedef struct {
      int           ch;
      logic [W-1:0] src;
      logic [W-1:0] dst;
      logic [15:0]  sz;
   } desc_t;

   desc_t ack_q[$];
   desc_t start_q[$];
   int    done_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    model_last = N-1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Round-robin rule: first requester searching upward from last+1, wrapping.
   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic all_out_zero();
      return ~|{ch_ack, ch_done, rd_start, rd_src_addr, rd_size, wr_start,
                wr_dst_addr, wr_size, busy, cur_ch};
   endfunction

   task automatic set_desc(input int c, input logic [W-1:0] s, input logic [W-1:0] d, input logic [15:0] z);
      ch_src_addr[c*W +: W] = s;
      ch_dst_addr[c*W +: W] = d;
      ch_size[c*16 +: 16]   = z;
   endtask

   task automatic rand_desc();
      for (int c = 0; c < N; c++) begin
         int unsigned r;
         logic [15:0] z;
         r = $urandom_range(0, 3);
         z = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
         set_desc(c, $urandom, $urandom, z);
      end
   endtask

   // rd_d/wr_d: cycle offset from the first WAIT cycle for each done pulse (negative = never).
   // rst_at >= 0: assert reset at that offset instead of completing.
   task automatic run_xfer(input logic [N-1:0] mask, input int rd_d, input int wr_d,
                           input int rst_at, output int win);
      int    exp_w;
      int    cnt;
      int    last;
      desc_t e;
      win   = -1;
      exp_w = rr_pick(mask, model_last);
      e.ch  = exp_w;
      e.src = ch_src_addr[exp_w*W +: W];
      e.dst = ch_dst_addr[exp_w*W +: W];
      e.sz  = ch_size[exp_w*16 +: 16];
      ack_q.push_back(e);
      start_q.push_back(e);
      @(negedge clk);
      ch_req = mask;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (ch_ack == '0 && cnt < 20);
      check("ack_latency", cnt, 1);
      if (ch_ack == '0) begin
         ch_req = '0;
         return;
      end
      for (int c = 0; c < N; c++) if (ch_ack[c]) win = c;
      ch_req[exp_w] = 1'b0;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!rd_start && cnt < 20);
      check("start_latency", cnt, 1);
      last = (rd_d > wr_d) ? rd_d : wr_d;
`ifdef DMA_SCHED_TIMEOUT_EN
      if (rd_d < 0 || wr_d < 0) last = TO - 1;
`endif
      if (rst_at < 0) done_q.push_back(exp_w);
      for (int t = 0; t <= last; t++) begin
         if (t > 0) @(negedge clk);
         check("no_early_done", ch_done, 0);
         check("busy_wait", busy, 1);
         rd_done = (t == rd_d);
         wr_done = (t == wr_d);
         if (t == rst_at) begin
            rd_done = 1'b0;
            wr_done = 1'b0;
            #2 rst_n = 1'b0;
            #1 check("reset_mid_xfer", all_out_zero(), 1);
            ch_req = '0;
            @(negedge clk);
            rst_n = 1'b1;
            model_last = N-1;
            return;
         end
      end
      @(negedge clk);
      rd_done = 1'b0;
      wr_done = 1'b0;
      check("done_vec", ch_done, 64'(1) << exp_w);
`ifdef DMA_SCHED_TIMEOUT_EN
      check("err_flag", err, (rd_d < 0 || wr_d < 0) ? 1 : 0);
`endif
      model_last = exp_w;
      ch_req = '0;
      @(negedge clk);
      check("busy_clear", busy, 0);
      check("done_single", ch_done, 0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents ack, start or done.
   initial begin : monitor
      desc_t e;
      int    dch;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ch_ack != '0) begin
               if (ack_q.size() == 0) check("ack_unexpected", ch_ack, 0);
               else begin
                  e = ack_q.pop_front();
                  check("ack_vec", ch_ack, 64'(1) << e.ch);
                  check("ack_cur_ch", cur_ch, e.ch);
                  check("ack_busy", busy, 1);
               end
            end
            if (rd_start || wr_start) begin
               if (start_q.size() == 0) check("start_unexpected", {rd_start, wr_start}, 0);
               else begin
                  e = start_q.pop_front();
                  check("start_pair", {rd_start, wr_start}, 2'b11);
                  check("rd_src_addr", rd_src_addr, e.src);
                  check("wr_dst_addr", wr_dst_addr, e.dst);
                  check("rd_size", rd_size, e.sz);
                  check("wr_size", wr_size, e.sz);
                  check("start_cur_ch", cur_ch, e.ch);
               end
            end
            if (ch_done != '0) begin
               if (done_q.size() == 0) check("done_unexpected", ch_done, 0);
               else begin
                  dch = done_q.pop_front();
                  check("mon_done_vec", ch_done, 64'(1) << dch);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int w;
      int rr_exp[6];
      rr_exp = '{0, 1, 2, 3, 0, 1};
      rst_n = 1'b0;
      ch_req = '0;
      rd_done = 1'b0;
      wr_done = 1'b0;
      ch_src_addr = '0;
      ch_dst_addr = '0;
      ch_size = '0;
      #1 check("reset_outputs", all_out_zero(), 1);
      repeat (2) @(negedge clk);
      check("reset_hold", all_out_zero(), 1);
      rst_n = 1'b1;

      // All channels requesting: strict rotation from channel 0.
      for (int i = 0; i < 6; i++) begin
         rand_desc();
         run_xfer(4'b1111, $urandom_range(0, 3), $urandom_range(0, 3), -1, w);
         check("rr_order", w, rr_exp[i]);
      end

      set_desc(0, 32'h1000, 32'h8000, 16'h0300);
      run_xfer(4'b0001, 1, 6, -1, w);
      check("hold_src", rd_src_addr, 32'h1000);
      check("hold_dst", wr_dst_addr, 32'h8000);
      check("hold_size", wr_size, 16'h0300);

      rand_desc();
      run_xfer(4'b0100, 5, 2, -1, w);
      run_xfer(4'b0100, 3, 3, -1, w);
      run_xfer(4'b0100, 2, 25, -1, w);

      @(negedge clk); rd_done = 1'b1; wr_done = 1'b1;
      @(negedge clk); rd_done = 1'b0; wr_done = 1'b0;
      @(negedge clk);
      check("spurious_idle_busy", busy, 0);
      check("spurious_idle_done", ch_done, 0);
      run_xfer(4'b0010, 3, 6, -1, w);

      run_xfer(4'b0100, 1, 30, 5, w);
      run_xfer(4'b0010, 4, 2, -1, w);
      check("post_reset_grant", w, 1);

`ifdef DMA_SCHED_TIMEOUT_EN
      run_xfer(4'b0001, 3, -1, -1, w);
      run_xfer(4'b0010, 1, 1, -1, w);
`endif

      for (int i = 0; i < 12; i++) begin
         rand_desc();
         run_xfer(4'($urandom_range(1, 15)), $urandom_range(0, 6), $urandom_range(0, 6), -1, w);
      end

      repeat (3) @(negedge clk);
      check("queues_empty", ack_q.size() + start_q.size() + done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
